// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain bitstream loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Number of configuration words needed to cover a chain of chain_len flops.
    function automatic int num_words(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer feeding ccff_head: accepts configuration words and presents
// one bit per shift cycle, LSB first, with zero-bubble back-to-back words.
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 22,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              load,
    input  logic              active,
    input  logic [CNT_W-1:0]  issued,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              issue
);

    localparam int NUM_WORDS = num_words(CHAIN_LEN, WORD_W);
    localparam int REM_W     = $clog2(WORD_W + 1);
    localparam int WC_W      = $clog2(NUM_WORDS + 1);

    logic [WORD_W-1:0] word_buf;
    logic [REM_W-1:0]  rem;
    logic [WC_W-1:0]   words_in;

    logic              room;
    logic              accept;
    logic [REM_W-1:0]  rem_next;
    logic [WC_W-1:0]   words_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        room       = active && (issued < CNT_W'(CHAIN_LEN));
        accept     = room && cfg_valid && cfg_ready && (rem == '0);
        issue      = room && ((rem != '0) || accept);
        words_next = words_in + WC_W'(accept);
        rem_next   = rem;
        if (accept) begin
            rem_next = REM_W'(WORD_W - 1);
        end else if (issue) begin
            rem_next = rem - REM_W'(1);
        end
    end

    // cfg_ready is registered: it rises in the cycle the last buffered bit is on
    // ccff_head, so the next word lands exactly when the buffer drains.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            word_buf  <= '0;
            rem       <= '0;
            words_in  <= '0;
            cfg_ready <= 1'b0;
            ccff_head <= 1'b0;
        end else if (load) begin
            rem       <= '0;
            words_in  <= '0;
            cfg_ready <= (NUM_WORDS > 0);
        end else if (active) begin
            if (accept) begin
                ccff_head <= cfg_data[0];
                word_buf  <= cfg_data >> 1;
            end else if (issue) begin
                ccff_head <= word_buf[0];
                word_buf  <= word_buf >> 1;
            end
            rem       <= rem_next;
            words_in  <= words_next;
            cfg_ready <= (rem_next == '0) && (words_next < WC_W'(NUM_WORDS));
        end else begin
            rem       <= '0;
            words_in  <= '0;
            cfg_ready <= 1'b0;
        end
    end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Programming-side driver for a tile configuration chain: serialises words onto
// ccff_head, gates the chain clock, and packs ccff_tail bits into readback words.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 22,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] rb_buf;
    logic [IDX_W-1:0]  rb_idx;

    logic              start_ok;
    logic              active;
    logic              issue;
    logic              last_shift;
    logic              word_full;
    logic [CNT_W-1:0]  issued;
    logic [WORD_W-1:0] rb_next;

    always_comb begin
        start_ok   = start && !abort && (state != ST_SHIFT);
        active     = (state == ST_SHIFT) && !abort;
        // Bits already committed: completed shifts plus the one on ccff_head now.
        issued     = bit_cnt + CNT_W'(ccff_clk_en);
        last_shift = active && ccff_clk_en && (bit_cnt == CNT_W'(CHAIN_LEN - 1));
        word_full  = (rb_idx == IDX_W'(WORD_W - 1));
        rb_next    = rb_buf;
        rb_next[rb_idx] = ccff_tail;
    end

    ccff_word_serializer #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W),
        .CNT_W     (CNT_W)
    ) u_serializer (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .load         (start_ok),
        .active       (active),
        .issued       (issued),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .ccff_head    (ccff_head),
        .issue        (issue)
    );

    // ccff_clk_en comes straight off this flop so the downstream ICG never sees
    // a combinational glitch; the async reset drops it without a clock edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            rb_buf      <= '0;
            rb_idx      <= '0;
            ccff_clk_en <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (abort) begin
                state       <= ST_IDLE;
                ccff_clk_en <= 1'b0;
                busy        <= 1'b0;
                done        <= 1'b0;
                rb_buf      <= '0;
                rb_idx      <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        ccff_clk_en <= 1'b0;
                        if (start) begin
                            state   <= ST_SHIFT;
                            bit_cnt <= '0;
                            rb_buf  <= '0;
                            rb_idx  <= '0;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end
                    end
                    ST_SHIFT: begin
                        ccff_clk_en <= issue;
                        if (ccff_clk_en) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (word_full || last_shift) begin
                                // Unfilled upper bits of a final partial word stay zero.
                                rd_data  <= rb_next;
                                rd_valid <= 1'b1;
                                rb_buf   <= '0;
                                rb_idx   <= '0;
                            end else begin
                                rb_buf <= rb_next;
                                rb_idx <= rb_idx + IDX_W'(1);
                            end
                        end
                        if (last_shift) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state       <= ST_IDLE;
                        ccff_clk_en <= 1'b0;
                        busy        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench: a behavioural 22-flop chain sits on ccff_head/ccff_tail and
// expected readback words are queued at each start, then checked by a monitor.
module tb_ccff_bitstream_loader;

    localparam int CHAIN_LEN = 22;
    localparam int WORD_W    = 8;
    localparam int NW        = 3;

    logic              prog_clk = 1'b0;
    logic              prog_reset_n;
    logic              start;
    logic              abort;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              ccff_head;
    logic              ccff_clk_en;
    logic              ccff_tail;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) dut (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .start        (start),
        .abort        (abort),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .ccff_head    (ccff_head),
        .ccff_clk_en  (ccff_clk_en),
        .ccff_tail    (ccff_tail),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .busy         (busy),
        .done         (done)
    );

    // Behavioural chain: bit 0 is the flop next to ccff_tail.
    logic [CHAIN_LEN-1:0] chain = '0;
    logic [CHAIN_LEN-1:0] preload_val = '0;
    logic                 preload_req = 1'b0;
    assign ccff_tail = chain[0];

    always @(posedge prog_clk) begin
        if (preload_req) chain <= preload_val;
        else if (ccff_clk_en) chain <= {ccff_head, chain[CHAIN_LEN-1:1]};
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Scoreboard and per-load bookkeeping.
    logic [WORD_W-1:0]    rd_q[$];
    logic [WORD_W-1:0]    cur_words[NW];
    logic [CHAIN_LEN-1:0] exp_chain;
    int shifts      = 0;
    int first_shift = -1;
    int last_shift  = -1;
    int cyc         = 0;
    logic head_prev = 1'b0;
    logic done_prev = 1'b0;

    always @(negedge prog_clk) begin
        cyc++;
        if (prog_reset_n) begin
            if (ccff_clk_en) begin
                shifts++;
                if (first_shift < 0) first_shift = cyc;
                last_shift = cyc;
            end else if (busy) begin
                check("head_hold_in_stall", ccff_head, head_prev);
            end
            if (rd_valid) begin
                if (rd_q.size() == 0) fail("rd_valid_unexpected");
                else check("rd_data", rd_data, rd_q.pop_front());
            end
            if (done && !done_prev) begin
                check("rd_valid_with_done", rd_valid, 1);
                check("clk_en_low_at_done", ccff_clk_en, 0);
                check("done_latency", cyc, last_shift + 1);
            end
        end
        head_prev = ccff_head;
        done_prev = done;
    end

    task automatic begin_load(input logic [CHAIN_LEN-1:0] pre, input bit do_pre);
        logic [NW*WORD_W-1:0] p;
        @(posedge prog_clk); #1;
        if (do_pre) begin
            preload_val = pre;
            preload_req = 1'b1;
            @(posedge prog_clk); #1;
            preload_req = 1'b0;
        end
        // Readback = current chain contents, LSB (tail side) first, zero-padded.
        p = '0;
        p[CHAIN_LEN-1:0] = chain;
        for (int k = 0; k < NW; k++) rd_q.push_back(p[k*WORD_W +: WORD_W]);
        for (int i = 0; i < CHAIN_LEN; i++) exp_chain[i] = cur_words[i / WORD_W][i % WORD_W];
        shifts      = 0;
        first_shift = -1;
        last_shift  = -1;
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        @(negedge prog_clk);
        check("busy_after_start", busy, 1);
        check("done_cleared_by_start", done, 0);
        @(posedge prog_clk); #1;
    endtask

    // Called just after a rising edge; stall = cycles cfg_ready is left unanswered.
    task automatic send_word(input logic [WORD_W-1:0] w, input int stall);
        bit got;
        if (stall > 0) begin
            got = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (cfg_ready) begin got = 1'b1; break; end
                @(posedge prog_clk); #1;
            end
            if (!got) fail("ready_timeout_stall");
            repeat (stall) @(posedge prog_clk);
            #1;
        end
        cfg_data  = w;
        cfg_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cfg_ready) begin got = 1'b1; break; end
            @(posedge prog_clk); #1;
        end
        @(posedge prog_clk); #1;
        cfg_valid = 1'b0;
        if (!got) fail("ready_timeout");
    endtask

    task automatic finish_load(input int span);
        bit got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge prog_clk);
            if (done) begin got = 1'b1; break; end
        end
        if (!got) fail("done_timeout");
        @(posedge prog_clk); #1;
        check("shift_count", shifts, CHAIN_LEN);
        check("shift_span", last_shift - first_shift + 1, span);
        check("chain_contents", chain, exp_chain);
        check("rd_pulses_outstanding", rd_q.size(), 0);
        check("busy_low_when_done", busy, 0);
        check("cfg_ready_low_when_done", cfg_ready, 0);
    endtask

    task automatic random_words();
        for (int k = 0; k < NW; k++) cur_words[k] = WORD_W'($urandom);
    endtask

    initial begin
        int st1, st2, s;
        prog_reset_n = 1'b0;
        start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        repeat (2) @(posedge prog_clk);
        #1;
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_ccff_head", ccff_head, 0);
        check("rst_ccff_clk_en", ccff_clk_en, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        #2 prog_reset_n = 1'b1;

        // Back-to-back words over a known preload.
        cur_words = '{8'hA5, 8'h3C, 8'hFF};
        begin_load(22'h2AAAAA, 1'b1);
        for (int k = 0; k < NW; k++) send_word(cur_words[k], 0);
        finish_load(CHAIN_LEN);
        check("chain_directed", chain, 22'h3F3CA5);

        // Same load with a five-cycle supply gap after the first word.
        begin_load(22'h2AAAAA, 1'b1);
        send_word(cur_words[0], 0);
        send_word(cur_words[1], 5);
        send_word(cur_words[2], 0);
        finish_load(CHAIN_LEN + 5);
        check("chain_after_stall", chain, 22'h3F3CA5);

        // Randomised loads; one carries a start pulse in the middle of SHIFT.
        for (int it = 0; it < 6; it++) begin
            random_words();
            st1 = $urandom_range(0, 3);
            st2 = $urandom_range(0, 3);
            begin_load(CHAIN_LEN'($urandom), 1'b1);
            send_word(cur_words[0], 0);
            if (it == 2) begin
                fork
                    send_word(cur_words[1], st1);
                    begin
                        start = 1'b1;
                        @(posedge prog_clk); #1;
                        start = 1'b0;
                    end
                join
            end else begin
                send_word(cur_words[1], st1);
            end
            send_word(cur_words[2], st2);
            finish_load(CHAIN_LEN + st1 + st2);
        end

        // Abort from DONE clears done.
        abort = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0;
        @(negedge prog_clk);
        check("abort_from_done_clears_done", done, 0);

        // Abort after ten shifts; the following load must still be complete.
        random_words();
        begin_load(CHAIN_LEN'($urandom), 1'b1);
        send_word(cur_words[0], 0);
        cfg_data  = cur_words[1];
        cfg_valid = 1'b1;
        for (int i = 0; i < 100 && shifts < 10; i++) begin
            @(posedge prog_clk); #1;
        end
        check("shifts_before_abort", shifts, 10);
        abort     = 1'b1;
        cfg_valid = 1'b0;
        @(posedge prog_clk); #1;
        abort = 1'b0;
        rd_q.delete();
        @(negedge prog_clk);
        check("abort_clk_en", ccff_clk_en, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_cfg_ready", cfg_ready, 0);
        check("abort_rd_valid", rd_valid, 0);
        repeat (10) @(negedge prog_clk);
        check("abort_stays_idle", busy, 0);
        random_words();
        begin_load('0, 1'b0);
        for (int k = 0; k < NW; k++) send_word(cur_words[k], 0);
        finish_load(CHAIN_LEN);

        // start together with abort mid-load ends in IDLE.
        random_words();
        begin_load(CHAIN_LEN'($urandom), 1'b1);
        send_word(cur_words[0], 0);
        start = 1'b1;
        abort = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        abort = 1'b0;
        rd_q.delete();
        @(negedge prog_clk);
        check("start_abort_busy", busy, 0);
        check("start_abort_clk_en", ccff_clk_en, 0);
        check("start_abort_cfg_ready", cfg_ready, 0);
        repeat (3) @(negedge prog_clk);
        check("start_abort_stays_idle", busy, 0);

        // Asynchronous reset in the middle of a word.
        random_words();
        begin_load(CHAIN_LEN'($urandom), 1'b1);
        send_word(cur_words[0], 0);
        @(posedge prog_clk); #3;
        check("clk_en_before_reset", ccff_clk_en, 1);
        prog_reset_n = 1'b0;
        #1;
        check("mid_rst_clk_en", ccff_clk_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_cfg_ready", cfg_ready, 0);
        check("mid_rst_head", ccff_head, 0);
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_rd_data", rd_data, 0);
        rd_q.delete();
        s = shifts;
        repeat (2) @(posedge prog_clk);
        #3 prog_reset_n = 1'b1;
        repeat (4) @(negedge prog_clk);
        check("post_rst_idle", busy, 0);
        check("post_rst_no_shift", shifts, s);
        random_words();
        begin_load(CHAIN_LEN'($urandom), 1'b1);
        for (int k = 0; k < NW; k++) send_word(cur_words[k], 0);
        finish_load(CHAIN_LEN);

        repeat (3) @(posedge prog_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
